// File: rtl/sparc_exu_ccr_wbarb.sv
// sparc_exu_ccr_wbarb
//   Long-latency condition-code writeback arbiter. Divider CC results are queued
//   in a small FIFO and issued on the G-stage CCR write port whenever that port
//   is not claimed by a higher-priority op. The CC data follows one cycle later
//   on divcntl_ccr_cc_w2 so it lines up with the CCR block's W2 write.
//   Optional feature macro: CCR_WB_BYPASS_EN (empty FIFO + free port -> issue
//   the incoming result in its own cycle without queueing).
module sparc_exu_ccr_wbarb #(
  parameter int DEPTH = 2,
  parameter int CCW   = 8,
  parameter int TIDW  = 2
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic            se,
  input  logic            div_ccr_vld,
  input  logic            div_ccr_setcc,
  input  logic [CCW-1:0]  div_ccr_cc,
  input  logic [TIDW-1:0] div_ccr_tid,
  output logic            ccr_div_ack,
  input  logic            wb_busy_g,
  output logic            wb_ccr_setcc_g,
  output logic [TIDW-1:0] wb_ccr_thr_g,
  output logic [CCW-1:0]  divcntl_ccr_cc_w2,
  output logic [3:0]      ccr_wb_pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [CCW-1:0]  cc;
    logic [TIDW-1:0] tid;
  } ent_t;

  ent_t            mem [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt;
  logic [CCW-1:0]  cc_w2_q;

  logic full, empty, push, pop, byp;
  ent_t head;

  // scan enable has no functional role here
  logic unused_se;
  assign unused_se = se;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

`ifdef CCR_WB_BYPASS_EN
  // Empty queue and free port: hand the incoming result straight to G
  assign byp = arst_l & empty & ~wb_busy_g & div_ccr_vld & div_ccr_setcc;
`else
  assign byp = 1'b0;
`endif

  // Ack depends only on registered fullness, never on this cycle's pop
  assign ccr_div_ack = arst_l & div_ccr_vld & ~full;
  assign push        = ccr_div_ack & div_ccr_setcc & ~byp;
  assign pop         = ~empty & ~wb_busy_g;

  assign wb_ccr_setcc_g    = pop | byp;
  assign wb_ccr_thr_g      = pop ? head.tid : (byp ? div_ccr_tid : '0);
  assign divcntl_ccr_cc_w2 = cc_w2_q;

  // Pointer, occupancy and per-entry valid tracking
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + AW'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + AW'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload storage; validity is tracked separately so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cc: div_ccr_cc, tid: div_ccr_tid};
  end

  // CC data register: captures whatever issued at G so it appears at W2
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l)  cc_w2_q <= '0;
    else if (pop) cc_w2_q <= head.cc;
    else if (byp) cc_w2_q <= div_ccr_cc;
  end

  // Per-thread pending: queued entries, minus the one leaving this cycle
  always_comb begin
    ccr_wb_pending = '0;
    for (int t = 0; t < 4; t++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_vld[e] && !(pop && (rd_ptr == AW'(e))) && (mem[e].tid == TIDW'(t)))
          ccr_wb_pending[t] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sparc_exu_ccr_wbarb.sv
// Scoreboard bench for sparc_exu_ccr_wbarb (default build, no bypass).
// Driver pushes the expected {tid,cc} when a setcc result is acked; the
// monitor pops on every wb_ccr_setcc_g and checks cc_w2 the following cycle.
module tb_sparc_exu_ccr_wbarb;
  logic       clk = 1'b0, arst_l = 1'b0, se = 1'b0;
  logic       vld = 1'b0, setcc = 1'b0, busy = 1'b0;
  logic [7:0] cc = '0;
  logic [1:0] tid = '0;
  logic       ack, setcc_g;
  logic [1:0] thr;
  logic [7:0] cc_w2;
  logic [3:0] pend;

  sparc_exu_ccr_wbarb dut (
    .clk(clk), .arst_l(arst_l), .se(se),
    .div_ccr_vld(vld), .div_ccr_setcc(setcc), .div_ccr_cc(cc), .div_ccr_tid(tid),
    .ccr_div_ack(ack), .wb_busy_g(busy),
    .wb_ccr_setcc_g(setcc_g), .wb_ccr_thr_g(thr),
    .divcntl_ccr_cc_w2(cc_w2), .ccr_wb_pending(pend)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] tid; logic [7:0] cc; } exp_t;
  exp_t exp_q[$];
  int   nvec = 0, nerr = 0;
  bit   cc_chk = 1'b0;
  logic [7:0] cc_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: match every issue against the scoreboard
  always @(negedge clk) begin
    if (!arst_l) cc_chk = 1'b0;
    else begin
      if (cc_chk) begin
        chk("cc_w2", cc_w2, cc_exp);
        cc_chk = 1'b0;
      end
      if (setcc_g) begin
        if (exp_q.size() == 0) chk("spurious_setcc", setcc_g, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("thr", thr, e.tid);
          cc_exp = e.cc;
          cc_chk = 1'b1;
        end
      end
    end
  end

  task automatic push_item(input logic s, input logic [7:0] c, input logic [1:0] t, output int waits);
    vld = 1'b1; setcc = s; cc = c; tid = t; waits = 0;
    @(negedge clk);
    while (!ack && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!ack) chk("ack_timeout", ack, 1);
    else if (s) exp_q.push_back('{tid: t, cc: c});
    @(posedge clk); #1;
    vld = 1'b0; setcc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int w;

  initial begin
    // reset state
    #2;
    chk("rst_ack", ack, 0);
    chk("rst_setcc", setcc_g, 0);
    chk("rst_thr", thr, 0);
    chk("rst_cc_w2", cc_w2, 0);
    chk("rst_pend", pend, 0);
    idle(2);
    arst_l = 1'b1;
    idle(1);

    // single result, 1-cycle latency to G, data at W2
    push_item(1'b1, 8'hA5, 2'd2, w);
    chk("t2_ack_first", w, 0);
    @(negedge clk);
    chk("t2_setcc", setcc_g, 1);
    chk("t2_thr", thr, 2);
    @(negedge clk);
    chk("t2_cc_w2", cc_w2, 8'hA5);
    idle(2);

    // full FIFO holds third result until first pop
    busy = 1'b1;
    push_item(1'b1, 8'h11, 2'd0, w);
    push_item(1'b1, 8'h22, 2'd1, w);
    vld = 1'b1; setcc = 1'b1; cc = 8'h33; tid = 2'd3;
    @(negedge clk);
    chk("t3_full_ack", ack, 0);
    chk("t3_pend", pend, 4'b0011);
    @(negedge clk);
    chk("t3_full_ack2", ack, 0);
    @(posedge clk); #1;
    busy = 1'b0;
    @(negedge clk);
    chk("t3_ack_at_pop", ack, 0);
    chk("t3_issue", setcc_g, 1);
    chk("t3_pend_excl", pend, 4'b0010);
    push_item(1'b1, 8'h33, 2'd3, w);
    chk("t3_ack_after_pop", w, 0);
    idle(4);

    // busy stall holds a single entry
    busy = 1'b1;
    push_item(1'b1, 8'h5A, 2'd1, w);
    chk("t4_pend", pend, 4'b0010);
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall", setcc_g, 0);
    end
    @(posedge clk); #1;
    busy = 1'b0;
    idle(4);

    // setcc=0: ack only
    push_item(1'b0, 8'hFF, 2'd3, w);
    chk("t5_ack", w, 0);
    chk("t5_pend", pend, 0);
    idle(4);
    chk("t5_none_queued", exp_q.size(), 0);

    // wrap: 10 results with busy toggling each cycle
    fork
      begin
        for (int i = 0; i < 10; i++) push_item(1'b1, 8'h60 + 8'(i), 2'(i % 4), w);
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          busy = ~busy;
        end
      end
    join
    busy = 1'b0;
    idle(6);
    chk("t6_drain", exp_q.size(), 0);

    // reset mid-stream with two queued entries
    busy = 1'b1;
    push_item(1'b1, 8'hC1, 2'd2, w);
    push_item(1'b1, 8'hC2, 2'd3, w);
    chk("t1_pend_pre", pend, 4'b1100);
    arst_l = 1'b0;
    exp_q.delete();
    #1;
    chk("t1_ack", ack, 0);
    chk("t1_setcc", setcc_g, 0);
    chk("t1_thr", thr, 0);
    chk("t1_cc_w2", cc_w2, 0);
    chk("t1_pend", pend, 0);
    idle(2);
    arst_l = 1'b1;
    busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t1_no_setcc", setcc_g, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
